// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parameterised synchronous FIFO.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Enable-gated pointer counter; wraps naturally at 2**WIDTH.
module fifo_ptr_ctr #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (en) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered (STD) or first-word-fall-through read,
// threshold flags and sticky overflow/underflow indicators.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter fifo_mode_t  MODE       = FIFO_STD,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH > FIFO_DEPTH || AE_THRESH > FIFO_DEPTH) begin : g_bad_thresh
        $error("AF_THRESH and AE_THRESH must lie within 0..FIFO_DEPTH");
    end

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW-1:0]         count_q, count_d;
    logic                  wr_acc, rd_acc;
    logic                  overflow_q, underflow_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Extra pointer MSB tells a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    fifo_ptr_ctr #(.WIDTH(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (wr_acc),
        .value (wr_ptr)
    );

    fifo_ptr_ctr #(.WIDTH(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en    (rd_acc),
        .value (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            // A fresh error outranks a same-cycle clear.
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= PW'(AF_THRESH));
    assign almost_empty = (count_q <= PW'(AE_THRESH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign data_out   = mem[rd_ptr[AW-1:0]];
        assign data_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem[rd_ptr[AW-1:0]];
                end
            end
        end

        assign data_out   = dout_q;
        assign data_valid = valid_q;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives an STD and an FWFT instance with shared stimulus and checks both
// against a queue-based model every cycle, plus fixed-value scenario checks.
module tb_param_sync_fifo;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] s_dout, f_dout;
    logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] s_count, f_count;

    int checks = 0;
    int errors = 0;

    param_sync_fifo #(
        .DATA_WIDTH (8), .FIFO_DEPTH (4), .MODE (FIFO_STD), .AF_THRESH (3), .AE_THRESH (1)
    ) u_std (
        .clk (clk), .rst (rst), .wr_en (wr_en), .data_in (din), .rd_en (rd_en),
        .err_clr (err_clr), .data_out (s_dout), .data_valid (s_dv), .full (s_full),
        .empty (s_empty), .almost_full (s_af), .almost_empty (s_ae), .count (s_count),
        .overflow (s_ovf), .underflow (s_unf)
    );

    param_sync_fifo #(
        .DATA_WIDTH (8), .FIFO_DEPTH (4), .MODE (FIFO_FWFT), .AF_THRESH (3), .AE_THRESH (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .wr_en (wr_en), .data_in (din), .rd_en (rd_en),
        .err_clr (err_clr), .data_out (f_dout), .data_valid (f_dv), .full (f_full),
        .empty (f_empty), .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
        .overflow (f_ovf), .underflow (f_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: contents as a queue, flags from its size.
    localparam int DEPTH = 4;
    logic [7:0] q[$];
    bit         m_ovf, m_unf, m_sv, model_ok;
    logic [7:0] m_sd;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_sv = 0;
            m_sd = 8'h00;
            model_ok = 1;
        end else begin
            bit was_full, was_empty, wr_ok, rd_ok;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            wr_ok = wr_en && !was_full;
            rd_ok = rd_en && !was_empty;
            m_sv = rd_ok;
            if (rd_ok) m_sd = q[0];
            if (wr_en && was_full) m_ovf = 1;
            else if (err_clr) m_ovf = 0;
            if (rd_en && was_empty) m_unf = 1;
            else if (err_clr) m_unf = 0;
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(din);
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            int n;
            n = q.size();
            chk("std_count", 32'(s_count), 32'(n));
            chk("fwft_count", 32'(f_count), 32'(n));
            chk("std_full", 32'(s_full), 32'(n == DEPTH));
            chk("fwft_full", 32'(f_full), 32'(n == DEPTH));
            chk("std_empty", 32'(s_empty), 32'(n == 0));
            chk("fwft_empty", 32'(f_empty), 32'(n == 0));
            chk("std_af", 32'(s_af), 32'(n >= 3));
            chk("fwft_af", 32'(f_af), 32'(n >= 3));
            chk("std_ae", 32'(s_ae), 32'(n <= 1));
            chk("fwft_ae", 32'(f_ae), 32'(n <= 1));
            chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
            chk("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
            chk("std_unf", 32'(s_unf), 32'(m_unf));
            chk("fwft_unf", 32'(f_unf), 32'(m_unf));
            chk("std_dv", 32'(s_dv), 32'(m_sv));
            chk("std_dout", 32'(s_dout), 32'(m_sd));
            chk("fwft_dv", 32'(f_dv), 32'(n != 0));
            if (n != 0) chk("fwft_head", 32'(f_dout), 32'(q[0]));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic c, input logic rs,
                       input logic [7:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        err_clr = c;
        rst = rs;
        din = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] e;
        cyc(0, 0, 0, 1, 8'h00);
        cyc(0, 0, 0, 1, 8'h00);
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_ae", 32'(s_ae), 32'd1);
        chk("rst_af", 32'(s_af), 32'd0);
        chk("rst_dv", 32'(s_dv), 32'd0);
        chk("rst_dout", 32'(s_dout), 32'd0);
        chk("rst_fwft_dv", 32'(f_dv), 32'd0);

        for (int i = 0; i < 4; i++) begin
            e = 8'hA1 + 8'(i);
            cyc(1, 0, 0, 0, e);
            if (i == 1) chk("af_at2", 32'(s_af), 32'd0);
            if (i == 2) chk("af_at3", 32'(s_af), 32'd1);
        end
        chk("fill_full", 32'(s_full), 32'd1);
        chk("fill_count", 32'(s_count), 32'd4);
        chk("fill_fwft_head", 32'(f_dout), 32'hA1);

        cyc(1, 0, 0, 0, 8'hFF);
        chk("ovf_set", 32'(s_ovf), 32'd1);
        chk("ovf_count", 32'(s_count), 32'd4);
        cyc(0, 0, 1, 0, 8'h00);
        chk("ovf_clr", 32'(s_ovf), 32'd0);

        for (int i = 0; i < 4; i++) begin
            e = 8'hA1 + 8'(i);
            chk("drain_fwft_head", 32'(f_dout), 32'(e));
            cyc(0, 1, 0, 0, 8'h00);
            chk("drain_dout", 32'(s_dout), 32'(e));
            chk("drain_dv", 32'(s_dv), 32'd1);
        end
        chk("drain_empty", 32'(s_empty), 32'd1);
        chk("drain_fwft_dv", 32'(f_dv), 32'd0);
        cyc(0, 0, 0, 0, 8'h00);
        chk("hold_dv", 32'(s_dv), 32'd0);
        chk("hold_dout", 32'(s_dout), 32'hA4);

        cyc(1, 1, 0, 0, 8'h55);
        chk("unf_set", 32'(s_unf), 32'd1);
        chk("unf_count", 32'(s_count), 32'd1);
        chk("unf_no_bypass", 32'(s_dv), 32'd0);
        cyc(0, 1, 1, 0, 8'h00);
        chk("unf_read", 32'(s_dout), 32'h55);
        chk("unf_clr", 32'(s_unf), 32'd0);

        cyc(1, 0, 0, 0, 8'h0E);
        cyc(1, 0, 0, 0, 8'h0F);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, 8'h10 + 8'(i));
            e = (i < 2) ? (8'h0E + 8'(i)) : (8'h10 + 8'(i - 2));
            chk("wrap_count", 32'(s_count), 32'd2);
            chk("wrap_dout", 32'(s_dout), 32'(e));
            chk("wrap_flags", 32'({s_ovf, s_unf}), 32'd0);
        end

        cyc(0, 0, 0, 1, 8'h00);
        cyc(1, 0, 0, 0, 8'h3C);
        chk("fwft_first", 32'(f_dout), 32'h3C);
        chk("fwft_first_dv", 32'(f_dv), 32'd1);
        cyc(0, 1, 0, 0, 8'h00);
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        chk("fwft_pop_dv", 32'(f_dv), 32'd0);

        cyc(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 8'h61 + 8'(i));
        chk("pre_rst_count", 32'(s_count), 32'd3);
        chk("pre_rst_unf", 32'(s_unf), 32'd1);
        cyc(1, 0, 0, 1, 8'h77);
        chk("mid_rst_count", 32'(s_count), 32'd0);
        chk("mid_rst_empty", 32'(s_empty), 32'd1);
        chk("mid_rst_flags", 32'({s_ovf, s_unf, f_ovf, f_unf}), 32'd0);
        chk("mid_rst_dv", 32'({s_dv, f_dv}), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int wp, rp;
            wp = (i < 1500) ? 70 : 40;
            rp = (i < 1500) ? 40 : 70;
            cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, 8'($urandom));
        end
        cyc(0, 0, 0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
